dk_filtrado: RTL and testbench
==============================

# dk_filtrado

Parametrised derivative-term engine for the PID controller datapath. It serves CH time-multiplexed channels. Per channel it computes d[k] = Kd·(y[k] − y[k−1]), rescales it with saturation instead of wrap-around, and applies a programmable first-order low-pass filter. It suppresses the derivative kick on the first sample after reset. It replaces the fixed-gain, single-channel, truncate-only derivative stage and feeds the PID summation stage with a valid strobe.

## Interface
- N, 18: signed sample/result width, two's complement.
- FRAC, 10: fractional bits of kd and alpha; 1.0 = 2^FRAC.
- CH, 2: number of channels, 1..8.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  sample strobe; honoured only in IDLE.
- yk  in  CH·N  channel c at bits [c·N+N−1 : c·N], signed.
- kd  in  N  signed gain, Q(N−FRAC).FRAC.
- alpha  in  FRAC+1  unsigned filter coefficient; values above 2^FRAC are treated as 2^FRAC (bypass).
- busy  out  1  high while a computation is in progress.
- dk_valid  out  1  one-cycle pulse when dk/sat are updated.
- dk  out  CH·N  filtered derivative per channel, same packing as yk.
- sat  out  CH  per-channel saturation flag for the last computation.

## Operation
- FSM states: IDLE, DIFF, MUL, FILT, DONE. Channel index ch counts 0..CH−1.
- IDLE with start=1:
  - capture yk, kd and clamped alpha into holding registers;
  - ch=0, busy=1, next state DIFF.
- Mid-computation changes on yk, kd or alpha have no effect.
- DIFF: diff = y[ch] − yprev[ch], computed in N+1 bits (no overflow). If first[ch]=1, diff is forced to 0.
- MUL: p_full = diff · kd in 2N+1 bits; p = p_full >>> FRAC (arithmetic shift, floor rounding).
- Saturation stage 1: p is clipped to [−2^(N−1), 2^(N−1)−1]; clipping sets sat_tmp[ch].
- FILT:
  - f_new = f[ch] + ((p − f[ch]) · alpha) >>> FRAC, with the product at full width and floor rounding;
  - f_new is saturated to N bits; clipping also sets sat_tmp[ch];
  - update f[ch]=f_new and yprev[ch]=y[ch], clear first[ch], store f_new in the shadow result.
- After FILT: if ch<CH−1, increment ch and go to DIFF; else go to DONE.
- DONE:
  - dk ← shadow results for all channels and sat ← sat_tmp, loaded atomically;
  - dk_valid=1, busy=0, return to IDLE.
- alpha=2^FRAC gives f_new=p exactly (unfiltered). alpha=0 holds f[ch].
- start asserted while busy=1 is ignored and is not queued.

## Timing
- Reset values: dk=0, sat=0, dk_valid=0, busy=0, state IDLE, all f and yprev 0, all first=1.
- Let E0 be the edge that samples start=1 in IDLE. busy rises at E0.
- Each channel occupies 3 edges: DIFF, MUL, FILT.
- dk, sat and dk_valid update at edge E0+3·CH+1, at which busy falls. dk_valid is high for exactly that one cycle.
- For CH=2, the result appears 7 cycles after the start edge.
- Earliest accepted restart: start sampled at edge E0+3·CH+2, the first edge back in IDLE.
- dk holds its value between dk_valid pulses.
- Reset asserted mid-computation aborts immediately:
  - all outputs and state return to reset values;
  - no dk_valid pulse is issued;
  - first is re-armed on all channels.

## Test plan
- Config N=18, FRAC=10, CH=2, unless noted.
- Post-reset first sample: yk={500,−300}, kd=1024, alpha=1024, start → dk={0,0}, sat=0, dk_valid exactly 7 cycles after the start edge.
- Gain and sign, alpha=1024:
  - kd=2048, ch0 500→600 → dk0=200;
  - kd=1024, ch1 600→100 → dk1=−500.
- Floor rounding, alpha=1024, kd=1536:
  - diff=+3 → dk=4;
  - diff=−3 → dk=−5.
- Saturation, kd=1024, alpha=1024: ch0 −131072 → 131071 → dk0=131071, sat[0]=1, sat[1]=0. The next normal sample clears sat[0].
- Filter, kd=1024, alpha=512, ch0 inputs 0, 1000, 1000 → dk0 0, 500, 250.
- Control:
  - start held high through busy → exactly one dk_valid per computation;
  - reset pulsed at cycle 3 of a computation → no dk_valid, outputs 0;
  - next sample treated as first (dk=0).

Source files
------------

// File: rtl/dk_filtrado.sv
// Multi-channel PID derivative term: gain, saturating rescale and first-order low-pass.
// Channels are processed one at a time; results are published together with a valid strobe.
module dk_filtrado #(
    parameter int N    = 18,
    parameter int FRAC = 10,
    parameter int CH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [CH*N-1:0] yk,
    input  logic [N-1:0]    kd,
    input  logic [FRAC:0]   alpha,
    output logic            busy,
    output logic            dk_valid,
    output logic [CH*N-1:0] dk,
    output logic [CH-1:0]   sat
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW = 2*N + 1;
    localparam int FW = N + FRAC + 3;
    localparam logic [FRAC:0] ONE = (FRAC+1)'(1) << FRAC;
    localparam logic signed [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, DIFF, MUL, FILT, DONE} state_t;

    state_t state, nstate;

    logic [CW-1:0]        ch;
    logic [CH*N-1:0]      yh;
    logic signed [N-1:0]  kdh;
    logic [FRAC:0]        alh;
    logic signed [N-1:0]  yprev  [CH];
    logic signed [N-1:0]  f      [CH];
    logic signed [N-1:0]  shadow [CH];
    logic [CH-1:0]        first;
    logic [CH-1:0]        sat_tmp;
    logic signed [N:0]    diff;
    logic signed [N-1:0]  p;
    logic                 psat;
    logic                 last;

    logic signed [N-1:0]  ysel;
    logic signed [N-1:0]  fcur;
    logic signed [N:0]    diff_c;
    logic signed [PW-1:0] pfull;
    logic signed [PW-1:0] pshift;
    logic signed [N-1:0]  p_c;
    logic                 psat_c;
    logic signed [N:0]    err;
    logic signed [FW-1:0] prod;
    logic signed [FW-1:0] fsum;
    logic signed [N-1:0]  fnew;
    logic                 fsat;

    assign last = (ch == CW'(CH-1));

    always_comb begin
        ysel   = yh[int'(ch)*N +: N];
        fcur   = f[ch];
        diff_c = first[ch] ? '0 : (N+1)'(ysel) - (N+1)'(yprev[ch]);
        pfull  = PW'(diff) * PW'(kdh);
        pshift = pfull >>> FRAC;
        // In range iff every bit above the result sign matches it
        psat_c = !((&pshift[PW-1:N-1]) || ~(|pshift[PW-1:N-1]));
        p_c    = psat_c ? (pshift[PW-1] ? MINV : MAXV) : pshift[N-1:0];
        err    = (N+1)'(p) - (N+1)'(fcur);
        prod   = FW'(err) * FW'($signed({1'b0, alh}));
        fsum   = FW'(fcur) + (prod >>> FRAC);
        fsat   = !((&fsum[FW-1:N-1]) || ~(|fsum[FW-1:N-1]));
        fnew   = fsat ? (fsum[FW-1] ? MINV : MAXV) : fsum[N-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: if (start) nstate = DIFF;
            DIFF: nstate = MUL;
            MUL:  nstate = FILT;
            FILT: nstate = last ? DONE : DIFF;
            DONE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch       <= '0;
            yh       <= '0;
            kdh      <= '0;
            alh      <= '0;
            diff     <= '0;
            p        <= '0;
            psat     <= 1'b0;
            first    <= '1;
            sat_tmp  <= '0;
            busy     <= 1'b0;
            dk_valid <= 1'b0;
            dk       <= '0;
            sat      <= '0;
            for (int c = 0; c < CH; c++) begin
                yprev[c]  <= '0;
                f[c]      <= '0;
                shadow[c] <= '0;
            end
        end else begin
            dk_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        yh      <= yk;
                        kdh     <= kd;
                        alh     <= (alpha > ONE) ? ONE : alpha;
                        ch      <= '0;
                        sat_tmp <= '0;
                        busy    <= 1'b1;
                    end
                end
                DIFF: diff <= diff_c;
                MUL: begin
                    p    <= p_c;
                    psat <= psat_c;
                end
                FILT: begin
                    f[ch]       <= fnew;
                    yprev[ch]   <= ysel;
                    shadow[ch]  <= fnew;
                    first[ch]   <= 1'b0;
                    sat_tmp[ch] <= psat | fsat;
                    if (!last) ch <= ch + CW'(1);
                end
                DONE: begin
                    for (int c = 0; c < CH; c++)
                        dk[c*N +: N] <= shadow[c];
                    sat      <= sat_tmp;
                    dk_valid <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dk_filtrado.sv
// Directed bench for dk_filtrado: latency, gain, rounding, saturation,
// filtering, start handling and mid-computation reset.
module tb_dk_filtrado;

    localparam int N    = 18;
    localparam int FRAC = 10;
    localparam int CH   = 2;

    logic            clk;
    logic            reset;
    logic            start;
    logic [CH*N-1:0] yk;
    logic [N-1:0]    kd;
    logic [FRAC:0]   alpha;
    logic            busy;
    logic            dk_valid;
    logic [CH*N-1:0] dk;
    logic [CH-1:0]   sat;

    int errors = 0;
    int checks = 0;
    int cyc;
    int pulses;

    dk_filtrado #(.N(N), .FRAC(FRAC), .CH(CH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .yk       (yk),
        .kd       (kd),
        .alpha    (alpha),
        .busy     (busy),
        .dk_valid (dk_valid),
        .dk       (dk),
        .sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dk0();
        return int'($signed(dk[N-1:0]));
    endfunction

    function automatic int dk1();
        return int'($signed(dk[2*N-1:N]));
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int y0, input int y1, input int k, input int a);
        yk    = {N'(y1), N'(y0)};
        kd    = N'(k);
        alpha = (FRAC+1)'(a);
    endtask

    task automatic sample(input int y0, input int y1, input int k, input int a);
        @(negedge clk);
        drive(y0, y1, k, a);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // scramble inputs; the held copies must be used
        yk    = ~yk;
        kd    = '0;
        alpha = '0;
        chk("busy_rise", int'(busy), 1);
        cyc = 0;
        while (!dk_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", cyc, 7);
        chk("busy_fall", int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dk", int'(dk), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_valid", int'(dk_valid), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;

        sample(500, -300, 1024, 1024);
        chk("first_dk0", dk0(), 0);
        chk("first_dk1", dk1(), 0);
        chk("first_sat", int'(sat), 0);
        @(posedge clk);
        #1;
        chk("valid_pulse", int'(dk_valid), 0);
        chk("dk_hold", dk0(), 0);

        sample(600, 600, 2048, 1024);
        chk("gain2_dk0", dk0(), 200);
        chk("gain2_dk1", dk1(), 1800);

        sample(600, 100, 1024, 2047);
        chk("gain1_dk0", dk0(), 0);
        chk("neg_dk1", dk1(), -500);

        sample(603, 97, 1536, 1024);
        chk("floor_pos", dk0(), 4);
        chk("floor_neg", dk1(), -5);

        sample(-131072, 97, 1024, 1024);
        chk("satlo_dk0", dk0(), -131072);
        chk("satlo_sat", int'(sat), 1);

        sample(131071, 97, 1024, 1024);
        chk("sathi_dk0", dk0(), 131071);
        chk("sathi_dk1", dk1(), 0);
        chk("sathi_sat", int'(sat), 1);

        sample(131071, 97, 1024, 1024);
        chk("satclr_dk0", dk0(), 0);
        chk("satclr_sat", int'(sat), 0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sample(0, 0, 1024, 512);
        chk("filt_0", dk0(), 0);
        sample(1000, 0, 1024, 512);
        chk("filt_1", dk0(), 500);
        sample(1000, 0, 1024, 512);
        chk("filt_2", dk0(), 250);
        chk("filt_ch1", dk1(), 0);

        // start held high through the whole computation
        @(negedge clk);
        drive(1000, 0, 1024, 512);
        start  = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            pulses += int'(dk_valid);
        end
        start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            pulses += int'(dk_valid);
        end
        chk("held_pulses", pulses, 1);
        chk("held_dk0", dk0(), 125);

        // reset during the third cycle of a computation
        @(negedge clk);
        drive(2000, 0, 1024, 512);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_dk", int'(dk), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(dk_valid), 0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            pulses += int'(dk_valid);
        end
        chk("abort_pulses", pulses, 0);

        sample(5000, -5000, 1024, 1024);
        chk("rearm_dk0", dk0(), 0);
        chk("rearm_dk1", dk1(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
